instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept.
- in_mnem  in  6  mnemonic code (package enum).
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_imm  in  16  immediate / branch offset.
- in_target  in  26  jump target.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded MIPS word.
- out_illegal  out  1  word came from an unsupported mnemonic.
- count  out  16  accepted-request counter.

Function
REQ-002 SHALL accept a request on a clk edge with in_valid=1 and in_ready=1 (push); SHALL pop on a clk edge with out_valid=1 and out_ready=1.
REQ-003 SHALL encode combinationally at input and store {illegal, word} in a 4-entry in-order FIFO; out_* SHALL reflect the FIFO head.
REQ-004 Latency: a push into an empty FIFO SHALL set out_valid=1 in the following cycle; no bypass.
REQ-005 in_ready SHALL equal "FIFO not full"; it SHALL be independent of same-cycle out_ready.
REQ-006 Simultaneous push and pop with 1-3 entries: occupancy unchanged, order kept.
REQ-007 Pointers SHALL wrap modulo 4; occupancy is held in a 3-bit counter 0..4.
REQ-008 R-type: op=0, funct per mnemonic. Shift-immediate (sll/srl/sra) SHALL force rs=0. jr SHALL force rt=rd=shamt=0. jalr SHALL force rt=shamt=0. mult/div family SHALL force rd=shamt=0. mfhi/mflo SHALL use rd only. mthi/mtlo SHALL use rs only.
REQ-009 I-type: {op, rs, rt, imm}. lui SHALL force rs=0. bgtz/blez/bltz SHALL force rt=0. bgez SHALL force rt=1; bgez/bltz op=000001.
REQ-010 J-type (j/jal): {op, in_target}.
REQ-011 Inputs outside the used fields SHALL be ignored; unused fields SHALL be zero.
REQ-012 Unsupported in_mnem SHALL store word 32'h0 with illegal=1; it is still accepted and counted.
REQ-013 count SHALL increment by 1 per push and wrap from 16'hFFFF to 0.

Reset
REQ-014 While reset=0: FIFO empty, pointers 0, count=0, out_valid=0, out_instr=0, out_illegal=0, in_ready=0.
REQ-015 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously).
REQ-016 After reset release, in_ready SHALL be 1 from the next clk edge.

Configuration
REQ-017 Macro INSTR_ENCODER_CP0_EN defined: SHALL encode the CP0/trap group:
- mfc0 = {010000, 00000, rt, rd, 11'b0}
- mtc0 = {010000, 00100, rt, rd, 11'b0}
- eret = 32'h42000018
- syscall = 32'h0000000C
- break = 32'h0000000D
REQ-018 Macro undefined: those five mnemonics SHALL be handled per REQ-012.

Structure
REQ-019 Package instr_enc_pkg SHALL hold:
- the 6-bit mnemonic enum covering the full supported set (ALU R/I, shifts, branches, jumps, loads/stores, HI/LO, CP0/trap);
- opcode and funct constants;
- constants for fixed words (eret, syscall, break).
REQ-020 The FIFO SHALL be sub-module instr_enc_fifo (depth 4, width 33); the encoder stays a combinational function inside instr_encoder.

Verification
REQ-021 addu, rs=1 rt=2 rd=3 -> out_instr=32'h00221821, out_illegal=0, one cycle after push.
REQ-022 lui, rs=7 rt=4 imm=16'h1234 -> 32'h3C041234 (rs ignored). bltz, rs=5 imm=16'hFFFE -> 32'h04A0FFFE. bgez, same fields -> 32'h04A1FFFE.
REQ-023 Five back-to-back pushes with out_ready=0:
- in_ready=0 after the 4th push; the 5th request is not accepted.
- Release out_ready: 4 words pop in order, then in_ready=1.
- count=4.
REQ-024 in_mnem=6'h3F -> out_instr=0, out_illegal=1, count increments.
REQ-025 eret with INSTR_ENCODER_CP0_EN defined -> 32'h42000018. Without the macro -> 0 with out_illegal=1.
REQ-026 Reset pulsed with 3 entries queued -> out_valid=0 and count=0 immediately; the next push appears one cycle later.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the MIPS instruction encoder.
// CP0/trap encodings are only generated when INSTR_ENCODER_CP0_EN is defined.
package instr_enc_pkg;

  typedef enum logic [5:0] {
    M_ADD     = 6'd0,
    M_ADDU    = 6'd1,
    M_SUB     = 6'd2,
    M_SUBU    = 6'd3,
    M_AND     = 6'd4,
    M_OR      = 6'd5,
    M_XOR     = 6'd6,
    M_NOR     = 6'd7,
    M_SLT     = 6'd8,
    M_SLTU    = 6'd9,
    M_SLL     = 6'd10,
    M_SRL     = 6'd11,
    M_SRA     = 6'd12,
    M_SLLV    = 6'd13,
    M_SRLV    = 6'd14,
    M_SRAV    = 6'd15,
    M_JR      = 6'd16,
    M_JALR    = 6'd17,
    M_MULT    = 6'd18,
    M_MULTU   = 6'd19,
    M_DIV     = 6'd20,
    M_DIVU    = 6'd21,
    M_MFHI    = 6'd22,
    M_MFLO    = 6'd23,
    M_MTHI    = 6'd24,
    M_MTLO    = 6'd25,
    M_ADDI    = 6'd26,
    M_ADDIU   = 6'd27,
    M_SLTI    = 6'd28,
    M_SLTIU   = 6'd29,
    M_ANDI    = 6'd30,
    M_ORI     = 6'd31,
    M_XORI    = 6'd32,
    M_LUI     = 6'd33,
    M_BEQ     = 6'd34,
    M_BNE     = 6'd35,
    M_BLEZ    = 6'd36,
    M_BGTZ    = 6'd37,
    M_BLTZ    = 6'd38,
    M_BGEZ    = 6'd39,
    M_LB      = 6'd40,
    M_LH      = 6'd41,
    M_LW      = 6'd42,
    M_LBU     = 6'd43,
    M_LHU     = 6'd44,
    M_SB      = 6'd45,
    M_SH      = 6'd46,
    M_SW      = 6'd47,
    M_J       = 6'd48,
    M_JAL     = 6'd49,
    M_MFC0    = 6'd50,
    M_MTC0    = 6'd51,
    M_ERET    = 6'd52,
    M_SYSCALL = 6'd53,
    M_BREAK   = 6'd54
  } mnem_e;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // REGIMM rt selectors and CP0 rs selectors
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;
  localparam logic [4:0] CP0_MF  = 5'b00000;
  localparam logic [4:0] CP0_MT  = 5'b00100;

  localparam logic [31:0] ERET_WORD    = 32'h4200_0018;
  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;
  localparam logic [31:0] BREAK_WORD   = 32'h0000_000D;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_WIDTH = 33;

  typedef struct packed {
    logic        illegal;
    logic [31:0] word;
  } enc_entry_t;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OP_SPECIAL, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// In-order FIFO holding encoded {illegal, word} entries; occupancy counter
// distinguishes full from empty when the pointers coincide.
module instr_enc_fifo
  import instr_enc_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once level covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: combinational encode at input, 4-deep output FIFO.
// Define INSTR_ENCODER_CP0_EN to enable the CP0/trap group (mfc0, mtc0, eret, syscall, break).
module instr_encoder
  import instr_enc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_illegal,
  output logic [15:0] count
);

  function automatic enc_entry_t encode(input logic [5:0] mnem,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [15:0] imm, input logic [25:0] target);
    enc_entry_t e;
    e.illegal = 1'b0;
    e.word    = '0;
    case (mnem)
      M_ADD:     e.word = r_word(rs, rt, rd, '0, FN_ADD);
      M_ADDU:    e.word = r_word(rs, rt, rd, '0, FN_ADDU);
      M_SUB:     e.word = r_word(rs, rt, rd, '0, FN_SUB);
      M_SUBU:    e.word = r_word(rs, rt, rd, '0, FN_SUBU);
      M_AND:     e.word = r_word(rs, rt, rd, '0, FN_AND);
      M_OR:      e.word = r_word(rs, rt, rd, '0, FN_OR);
      M_XOR:     e.word = r_word(rs, rt, rd, '0, FN_XOR);
      M_NOR:     e.word = r_word(rs, rt, rd, '0, FN_NOR);
      M_SLT:     e.word = r_word(rs, rt, rd, '0, FN_SLT);
      M_SLTU:    e.word = r_word(rs, rt, rd, '0, FN_SLTU);
      M_SLL:     e.word = r_word('0, rt, rd, shamt, FN_SLL);
      M_SRL:     e.word = r_word('0, rt, rd, shamt, FN_SRL);
      M_SRA:     e.word = r_word('0, rt, rd, shamt, FN_SRA);
      M_SLLV:    e.word = r_word(rs, rt, rd, '0, FN_SLLV);
      M_SRLV:    e.word = r_word(rs, rt, rd, '0, FN_SRLV);
      M_SRAV:    e.word = r_word(rs, rt, rd, '0, FN_SRAV);
      M_JR:      e.word = r_word(rs, '0, '0, '0, FN_JR);
      M_JALR:    e.word = r_word(rs, '0, rd, '0, FN_JALR);
      M_MULT:    e.word = r_word(rs, rt, '0, '0, FN_MULT);
      M_MULTU:   e.word = r_word(rs, rt, '0, '0, FN_MULTU);
      M_DIV:     e.word = r_word(rs, rt, '0, '0, FN_DIV);
      M_DIVU:    e.word = r_word(rs, rt, '0, '0, FN_DIVU);
      M_MFHI:    e.word = r_word('0, '0, rd, '0, FN_MFHI);
      M_MFLO:    e.word = r_word('0, '0, rd, '0, FN_MFLO);
      M_MTHI:    e.word = r_word(rs, '0, '0, '0, FN_MTHI);
      M_MTLO:    e.word = r_word(rs, '0, '0, '0, FN_MTLO);
      M_ADDI:    e.word = i_word(OP_ADDI, rs, rt, imm);
      M_ADDIU:   e.word = i_word(OP_ADDIU, rs, rt, imm);
      M_SLTI:    e.word = i_word(OP_SLTI, rs, rt, imm);
      M_SLTIU:   e.word = i_word(OP_SLTIU, rs, rt, imm);
      M_ANDI:    e.word = i_word(OP_ANDI, rs, rt, imm);
      M_ORI:     e.word = i_word(OP_ORI, rs, rt, imm);
      M_XORI:    e.word = i_word(OP_XORI, rs, rt, imm);
      M_LUI:     e.word = i_word(OP_LUI, '0, rt, imm);
      M_BEQ:     e.word = i_word(OP_BEQ, rs, rt, imm);
      M_BNE:     e.word = i_word(OP_BNE, rs, rt, imm);
      M_BLEZ:    e.word = i_word(OP_BLEZ, rs, '0, imm);
      M_BGTZ:    e.word = i_word(OP_BGTZ, rs, '0, imm);
      M_BLTZ:    e.word = i_word(OP_REGIMM, rs, RT_BLTZ, imm);
      M_BGEZ:    e.word = i_word(OP_REGIMM, rs, RT_BGEZ, imm);
      M_LB:      e.word = i_word(OP_LB, rs, rt, imm);
      M_LH:      e.word = i_word(OP_LH, rs, rt, imm);
      M_LW:      e.word = i_word(OP_LW, rs, rt, imm);
      M_LBU:     e.word = i_word(OP_LBU, rs, rt, imm);
      M_LHU:     e.word = i_word(OP_LHU, rs, rt, imm);
      M_SB:      e.word = i_word(OP_SB, rs, rt, imm);
      M_SH:      e.word = i_word(OP_SH, rs, rt, imm);
      M_SW:      e.word = i_word(OP_SW, rs, rt, imm);
      M_J:       e.word = {OP_J, target};
      M_JAL:     e.word = {OP_JAL, target};
`ifdef INSTR_ENCODER_CP0_EN
      M_MFC0:    e.word = {OP_COP0, CP0_MF, rt, rd, 11'b0};
      M_MTC0:    e.word = {OP_COP0, CP0_MT, rt, rd, 11'b0};
      M_ERET:    e.word = ERET_WORD;
      M_SYSCALL: e.word = SYSCALL_WORD;
      M_BREAK:   e.word = BREAK_WORD;
`else
      M_MFC0, M_MTC0, M_ERET, M_SYSCALL, M_BREAK: e.illegal = 1'b1;
`endif
      default:   e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  enc_entry_t enc;
  enc_entry_t head;
  logic       ready_en;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;

  always_comb begin
    enc = encode(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
  end

  // Holds in_ready low during reset and asserts it on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign in_ready  = ready_en & ~full;
  assign push      = in_valid & in_ready;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  instr_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (enc),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Stale storage is masked so an empty FIFO always presents zeros.
  assign out_instr   = out_valid ? head.word : '0;
  assign out_illegal = out_valid & head.illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    count <= '0;
    else if (push) count <= count + 16'd1;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (honours INSTR_ENCODER_CP0_EN).
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_mnem;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_illegal;
  logic [15:0] count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_count = '0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mnem     (in_mnem),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_shamt    (in_shamt),
    .in_imm      (in_imm),
    .in_target   (in_target),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_illegal (out_illegal),
    .count       (count)
  );

  typedef struct {
    logic [5:0]  mn;
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tg;
    logic [31:0] exp;
  } vec_t;

  task automatic set_fields(input logic [5:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [25:0] tg);
    in_mnem = mn; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tg;
  endtask

  task automatic drive_push(input logic [5:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [25:0] tg);
    set_fields(mn, rs, rt, rd, sh, imm, tg);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({in_ready, out_valid, out_illegal} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b want=000", {in_ready, out_valid, out_illegal});
    end
    checks++;
    if (out_instr !== 32'h0) begin
      failures++; $display("FAIL reset_instr got=%h want=00000000", out_instr);
    end
    checks++;
    if (count !== 16'h0) begin
      failures++; $display("FAIL reset_count got=%0d want=0", count);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_held_ready got=%b want=0", in_ready);
    end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++; $display("FAIL reset_release got=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_addu();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL addu_pre_valid got=%b want=0", out_valid);
    end
    drive_push(M_ADDU, 5'd1, 5'd2, 5'd3, 5'd9, 16'hABCD, 26'h3FFFFFF);
    exp_count++;
    checks++;
    if ({out_valid, out_illegal, out_instr} !== {1'b1, 1'b0, 32'h00221821}) begin
      failures++;
      $display("FAIL addu got=v%b i%b %h want=v1 i0 00221821", out_valid, out_illegal, out_instr);
    end
    checks++;
    if (count !== exp_count) begin
      failures++; $display("FAIL addu_count got=%0d want=%0d", count, exp_count);
    end
    drive_pop();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL addu_pop got=%b want=0", out_valid);
    end
  endtask

  task automatic test_vectors();
    vec_t v [12];
    v[0]  = '{M_LUI,  5'd7,  5'd4,  5'd9, 5'd3, 16'h1234, 26'h155_5555, 32'h3C041234};
    v[1]  = '{M_BLTZ, 5'd5,  5'd9,  5'd1, 5'd2, 16'hFFFE, 26'h0AB_CDEF, 32'h04A0FFFE};
    v[2]  = '{M_BGEZ, 5'd5,  5'd9,  5'd1, 5'd2, 16'hFFFE, 26'h0AB_CDEF, 32'h04A1FFFE};
    v[3]  = '{M_SLL,  5'd3,  5'd2,  5'd1, 5'd4, 16'hFFFF, 26'h3FF_FFFF, 32'h00020900};
    v[4]  = '{M_JR,   5'd31, 5'd5,  5'd6, 5'd7, 16'h1111, 26'h111_1111, 32'h03E00008};
    v[5]  = '{M_JALR, 5'd3,  5'd4,  5'd31,5'd5, 16'h2222, 26'h222_2222, 32'h0060F809};
    v[6]  = '{M_MULT, 5'd4,  5'd5,  5'd6, 5'd7, 16'h3333, 26'h333_3333, 32'h00850018};
    v[7]  = '{M_MFHI, 5'd1,  5'd2,  5'd8, 5'd3, 16'h4444, 26'h044_4444, 32'h00004010};
    v[8]  = '{M_SW,   5'd29, 5'd31, 5'd5, 5'd5, 16'h0010, 26'h155_5555, 32'hAFBF0010};
    v[9]  = '{M_J,    5'd1,  5'd1,  5'd1, 5'd1, 16'hFFFF, 26'h012_3456, 32'h08123456};
    v[10] = '{M_MTHI, 5'd9,  5'd2,  5'd3, 5'd4, 16'h5555, 26'h155_5555, 32'h01200011};
    v[11] = '{M_BEQ,  5'd1,  5'd2,  5'd7, 5'd7, 16'h0003, 26'h3FF_FFFF, 32'h10220003};
    for (int i = 0; i < 12; i++) begin
      drive_push(v[i].mn, v[i].rs, v[i].rt, v[i].rd, v[i].sh, v[i].imm, v[i].tg);
      exp_count++;
      checks++;
      if ({out_valid, out_illegal, out_instr} !== {1'b1, 1'b0, v[i].exp}) begin
        failures++;
        $display("FAIL vec%0d got=v%b i%b %h want=v1 i0 %h", i, out_valid, out_illegal,
                 out_instr, v[i].exp);
      end
      drive_pop();
    end
    checks++;
    if (count !== exp_count) begin
      failures++; $display("FAIL vec_count got=%0d want=%0d", count, exp_count);
    end
  endtask

  task automatic test_illegal();
    drive_push(6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF);
    exp_count++;
    checks++;
    if ({out_valid, out_illegal, out_instr} !== {1'b1, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL illegal got=v%b i%b %h want=v1 i1 00000000", out_valid, out_illegal, out_instr);
    end
    checks++;
    if (count !== exp_count) begin
      failures++; $display("FAIL illegal_count got=%0d want=%0d", count, exp_count);
    end
    drive_pop();
  endtask

  task automatic test_cp0();
    logic [32:0] exp_eret, exp_mfc0;
`ifdef INSTR_ENCODER_CP0_EN
    exp_eret = {1'b0, 32'h42000018};
    exp_mfc0 = {1'b0, 32'h40036000};
`else
    exp_eret = {1'b1, 32'h0};
    exp_mfc0 = {1'b1, 32'h0};
`endif
    drive_push(M_ERET, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1234, 26'h1234567);
    exp_count++;
    checks++;
    if ({out_illegal, out_instr} !== exp_eret) begin
      failures++; $display("FAIL eret got=%h want=%h", {out_illegal, out_instr}, exp_eret);
    end
    drive_pop();
    drive_push(M_MFC0, 5'd7, 5'd3, 5'd12, 5'd2, 16'hBEEF, 26'h0);
    exp_count++;
    checks++;
    if ({out_illegal, out_instr} !== exp_mfc0) begin
      failures++; $display("FAIL mfc0 got=%h want=%h", {out_illegal, out_instr}, exp_mfc0);
    end
    drive_pop();
    checks++;
    if (count !== exp_count) begin
      failures++; $display("FAIL cp0_count got=%0d want=%0d", count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    reset = 1'b0;
    #1 reset = 1'b1;
    exp_count = '0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_fields(M_ADDU, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0, 26'h0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== (i < 3)) begin
        failures++; $display("FAIL b2b_ready%0d got=%b want=%b", i, in_ready, (i < 3));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 16'd4) begin
      failures++; $display("FAIL b2b_count got=%0d want=4", count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_w = 32'h00220021 | (32'(i) << 11);
      checks++;
      if ({out_valid, out_instr} !== {1'b1, exp_w}) begin
        failures++; $display("FAIL b2b_pop%0d got=v%b %h want=v1 %h", i, out_valid, out_instr, exp_w);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL b2b_drained got=%b want=01", {out_valid, in_ready});
    end
    exp_count = 16'd4;
  endtask

  task automatic test_push_pop();
    logic [31:0] exp_q [$];
    for (int c = 0; c < 5; c++) begin
      set_fields(M_SUBU, 5'd1, 5'd1, 5'(c + 1), 5'd0, 16'h0, 26'h0);
      in_valid  = 1'b1;
      out_ready = (c >= 2);
      if (out_ready) begin
        checks++;
        if ({out_valid, out_instr} !== {1'b1, exp_q[0]}) begin
          failures++;
          $display("FAIL pp_head%0d got=v%b %h want=v1 %h", c, out_valid, out_instr, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      exp_q.push_back(32'h00210023 | (32'(c + 1) << 11));
      exp_count++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({out_valid, out_instr} !== {1'b1, exp_q[0]}) begin
        failures++;
        $display("FAIL pp_drain%0d got=v%b %h want=v1 %h", k, out_valid, out_instr, exp_q[0]);
      end
      void'(exp_q.pop_front());
      drive_pop();
    end
    checks++;
    if ({out_valid, count} !== {1'b0, exp_count}) begin
      failures++; $display("FAIL pp_end got=v%b c%0d want=v0 c%0d", out_valid, count, exp_count);
    end
  endtask

  task automatic test_reset_midway();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_push(M_ADDU, 5'd4, 5'd5, 5'(i), 5'd0, 16'h0, 26'h0);
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_illegal, out_instr, count} !== {3'b000, 32'h0, 16'h0}) begin
      failures++;
      $display("FAIL midrst got=v%b r%b i%b %h c%0d want=all zero", out_valid, in_ready,
               out_illegal, out_instr, count);
    end
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_ready got=%b want=1", in_ready);
    end
    drive_push(M_ORI, 5'd2, 5'd3, 5'd9, 5'd9, 16'h00FF, 26'h3FFFFFF);
    checks++;
    if ({out_valid, out_illegal, out_instr, count} !== {2'b10, 32'h344300FF, 16'd1}) begin
      failures++;
      $display("FAIL midrst_push got=v%b i%b %h c%0d want=v1 i0 344300FF c1", out_valid,
               out_illegal, out_instr, count);
    end
    drive_pop();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_pop got=%b want=0", out_valid);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_fields(6'h0, '0, '0, '0, '0, '0, '0);
    test_reset();
    test_addu();
    test_vectors();
    test_illegal();
    test_cp0();
    test_back_to_back();
    test_push_pop();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
